// File: rtl/ripple_counter_n_if.sv
// rtl/ripple_counter_n_if.sv - control and status bundle for the ripple counter
interface ripple_counter_n_if #(
    parameter int WIDTH = 4
);
    logic             EN;
    logic             UP_DN;
    logic             CLR_OVF;
    logic [WIDTH-1:0] Q;
    logic [WIDTH-1:0] Q_CAP;
    logic             TC;
    logic             OVF;
    logic             MODE;

    // Drives the controls and observes the count.
    modport master (
        output EN, UP_DN, CLR_OVF,
        input  Q, Q_CAP, TC, OVF, MODE
    );

    // The counter itself.
    modport slave (
        input  EN, UP_DN, CLR_OVF,
        output Q, Q_CAP, TC, OVF, MODE
    );
endinterface

// File: rtl/ripple_counter_n.sv
// rtl/ripple_counter_n.sv - WIDTH-generic asynchronous up/down ripple counter
module ripple_counter_n #(
    parameter int WIDTH = 4
) (
    input logic              CLK,
    input logic              RST,
    ripple_counter_n_if.slave bus
);
    localparam logic [WIDTH-1:0] ALL_ONES = '1;

    logic             en_r;
    logic             mode_r;
    logic             tc_r;
    logic             clr_r;
    logic             ovf_r;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] q_cap;
    logic             wrap_next;

    // Terminal condition for the direction currently in force; Q is settled at
    // the rising edge, so the comparison sees a stable value.
    assign wrap_next = mode_r ? (q == ALL_ONES) : (q == '0);

    // Rising-edge control and snapshot registers; the mode only moves while the
    // counter is quiet on both sides of the enable register, so a stage-clock
    // glitch from the flip finds every stage disabled.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            en_r   <= 1'b0;
            mode_r <= 1'b1;
            tc_r   <= 1'b0;
            clr_r  <= 1'b0;
            q_cap  <= '0;
        end else begin
            en_r  <= bus.EN;
            clr_r <= bus.CLR_OVF;
            tc_r  <= bus.EN && wrap_next;
            q_cap <= q;
            if (!en_r && !bus.EN) begin
                mode_r <= bus.UP_DN;
            end
        end
    end

    // Sticky wrap flag on the counting edge; a wrap beats a pending clear.
    always_ff @(negedge CLK or posedge RST) begin
        if (RST) begin
            ovf_r <= 1'b0;
        end else if (en_r && tc_r) begin
            ovf_r <= 1'b1;
        end else if (clr_r) begin
            ovf_r <= 1'b0;
        end
    end

    // Each stage is its own toggle flop clocked by the previous stage. In up
    // mode a stage clock falls when the lower bit falls (carry); in down mode
    // the inversion makes it fall when the lower bit rises (borrow).
    for (genvar i = 0; i < WIDTH; i++) begin : g_stage
        logic stage_clk;
        logic stage_q;

        if (i == 0) begin : g_lsb
            assign stage_clk = CLK;
        end else begin : g_upper
            assign stage_clk = q[i-1] ^ ~mode_r;
        end

        // Toggle on the falling edge of this stage's clock while enabled.
        always_ff @(negedge stage_clk or posedge RST) begin
            if (RST) begin
                stage_q <= 1'b0;
            end else if (en_r) begin
                stage_q <= ~stage_q;
            end
        end

        assign q[i] = stage_q;
    end

    assign bus.Q     = q;
    assign bus.Q_CAP = q_cap;
    assign bus.TC    = tc_r;
    assign bus.OVF   = ovf_r;
    assign bus.MODE  = mode_r;
endmodule

// File: tb/tb_ripple_counter_n.sv
// tb/tb_ripple_counter_n.sv - directed table-driven bench for ripple_counter_n
module tb_ripple_counter_n;
    logic clk = 1'b0;
    logic rst = 1'b0;

    ripple_counter_n_if #(.WIDTH(4)) bus4 ();
    ripple_counter_n_if #(.WIDTH(8)) bus8 ();

    ripple_counter_n #(.WIDTH(4)) dut4 (.CLK(clk), .RST(rst), .bus(bus4));
    ripple_counter_n #(.WIDTH(8)) dut8 (.CLK(clk), .RST(rst), .bus(bus8));

    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic       up_dn;
        logic       clr;
        logic [3:0] cap;
        logic       tc;
        logic [3:0] q;
        logic       ovf;
        logic       mode;
    } vec_t;

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic vec_t mk(logic en, logic up_dn, logic clr, logic [3:0] cap,
                                logic tc, logic [3:0] q, logic ovf, logic mode);
        vec_t v;
        v.en = en; v.up_dn = up_dn; v.clr = clr; v.cap = cap;
        v.tc = tc; v.q = q; v.ovf = ovf; v.mode = mode;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk); #1;
        @(negedge clk); #1;
    endtask

    initial begin
        logic [7:0] gate_en  [5];
        logic [7:0] gate_cap [5];

        bus4.EN = 1'b0; bus4.UP_DN = 1'b1; bus4.CLR_OVF = 1'b0;
        bus8.EN = 1'b0; bus8.UP_DN = 1'b1; bus8.CLR_OVF = 1'b0;

        // up count 0..15 wrap to 0,1
        for (int k = 1; k <= 17; k++)
            tbl.push_back(mk(1, 1, 0, 4'((k - 1) % 16), k == 16, 4'(k % 16), k >= 16, 1));
        tbl.push_back(mk(0, 1, 0,  1, 0,  1, 1, 1));
        // climb to 3, clear OVF, switch to down
        tbl.push_back(mk(1, 1, 0,  1, 0,  2, 1, 1));
        tbl.push_back(mk(1, 1, 0,  2, 0,  3, 1, 1));
        tbl.push_back(mk(0, 0, 1,  3, 0,  3, 0, 1));
        tbl.push_back(mk(0, 0, 0,  3, 0,  3, 0, 0));
        // down count through 0 -> 15
        tbl.push_back(mk(1, 0, 0,  3, 0,  2, 0, 0));
        tbl.push_back(mk(1, 0, 0,  2, 0,  1, 0, 0));
        tbl.push_back(mk(1, 0, 0,  1, 0,  0, 0, 0));
        tbl.push_back(mk(1, 0, 0,  0, 1, 15, 1, 0));
        tbl.push_back(mk(1, 0, 0, 15, 0, 14, 1, 0));
        // UP_DN flipped while counting: ignored until EN low for two edges
        tbl.push_back(mk(1, 1, 0, 14, 0, 13, 1, 0));
        tbl.push_back(mk(1, 1, 0, 13, 0, 12, 1, 0));
        tbl.push_back(mk(0, 1, 0, 12, 0, 12, 1, 0));
        tbl.push_back(mk(0, 1, 0, 12, 0, 12, 1, 1));
        tbl.push_back(mk(1, 1, 0, 12, 0, 13, 1, 1));
        // clear racing a wrap, then clear alone
        tbl.push_back(mk(1, 1, 0, 13, 0, 14, 1, 1));
        tbl.push_back(mk(1, 1, 0, 14, 0, 15, 1, 1));
        tbl.push_back(mk(1, 1, 1, 15, 1,  0, 1, 1));
        tbl.push_back(mk(0, 1, 1,  0, 0,  0, 0, 1));
        tbl.push_back(mk(0, 1, 0,  0, 0,  0, 0, 1));

        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
        chk("reset_q",    bus4.Q, 0);
        chk("reset_qcap", bus4.Q_CAP, 0);
        chk("reset_tc",   bus4.TC, 0);
        chk("reset_ovf",  bus4.OVF, 0);
        chk("reset_mode", bus4.MODE, 1);

        foreach (tbl[r]) begin
            bus4.EN = tbl[r].en; bus4.UP_DN = tbl[r].up_dn; bus4.CLR_OVF = tbl[r].clr;
            @(posedge clk); #1;
            chk($sformatf("row%0d_qcap", r), bus4.Q_CAP, tbl[r].cap);
            chk($sformatf("row%0d_tc", r),   bus4.TC,    tbl[r].tc);
            chk($sformatf("row%0d_mode", r), bus4.MODE,  tbl[r].mode);
            @(negedge clk); #1;
            chk($sformatf("row%0d_q", r),    bus4.Q,     tbl[r].q);
            chk($sformatf("row%0d_ovf", r),  bus4.OVF,   tbl[r].ovf);
        end

        // asynchronous reset in the middle of a down count at Q=9
        bus4.EN = 1'b0; bus4.UP_DN = 1'b0; bus4.CLR_OVF = 1'b0;
        repeat (2) cycle();
        chk("pre_rst_mode", bus4.MODE, 0);
        bus4.EN = 1'b1;
        repeat (7) cycle();
        chk("pre_rst_q",   bus4.Q, 9);
        chk("pre_rst_ovf", bus4.OVF, 1);
        @(posedge clk); #2;
        chk("pre_rst_qcap", bus4.Q_CAP, 9);
        rst = 1'b1;
        #1;
        chk("rst_q",    bus4.Q, 0);
        chk("rst_qcap", bus4.Q_CAP, 0);
        chk("rst_tc",   bus4.TC, 0);
        chk("rst_ovf",  bus4.OVF, 0);
        chk("rst_mode", bus4.MODE, 1);
        @(negedge clk); #1;
        chk("rst_hold_q", bus4.Q, 0);
        rst = 1'b0;
        cycle();
        chk("post_rst_q", bus4.Q, 1);
        bus4.EN = 1'b0; bus4.UP_DN = 1'b1;
        cycle();

        // WIDTH=8 enable gating
        rst = 1'b1; #1 rst = 1'b0;
        gate_en[0] = 1; gate_en[1] = 0; gate_en[2] = 1; gate_en[3] = 1; gate_en[4] = 0;
        gate_cap[0] = 1; gate_cap[1] = 1; gate_cap[2] = 2; gate_cap[3] = 3; gate_cap[4] = 3;
        for (int j = 0; j < 5; j++) begin
            bus8.EN = gate_en[j][0];
            @(posedge clk); #1;
            if (j > 0) chk($sformatf("w8_gate%0d_qcap", j - 1), bus8.Q_CAP, gate_cap[j - 1]);
            @(negedge clk); #1;
        end
        bus8.EN = 1'b0;
        @(posedge clk); #1;
        chk("w8_gate4_qcap", bus8.Q_CAP, gate_cap[4]);
        @(negedge clk); #1;

        // WIDTH=8 long run past the wrap
        rst = 1'b1; #1 rst = 1'b0;
        chk("w8_rst_ovf", bus8.OVF, 0);
        bus8.EN = 1'b1;
        repeat (300) @(negedge clk);
        #1 bus8.EN = 1'b0;
        chk("w8_300_q", bus8.Q, 44);
        @(posedge clk); #1;
        chk("w8_300_qcap", bus8.Q_CAP, 44);
        chk("w8_300_ovf",  bus8.OVF, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/ripple_counter_n.md
# ripple_counter_n

Parametrised asynchronous binary ripple counter. It is the WIDTH-generic successor to the team's 3-bit T-flip-flop up counter. It adds a runtime up/down mode, a registered count enable, a settled snapshot output, a registered terminal-count flag and a sticky overflow flag. It sits wherever a low-power divider or event counter is needed, and delivers both the live ripple value and a CLK-aligned, glitch-free copy.

## Interface
- WIDTH, 4, counter width in bits; legal range 2..32.
- CLK  input  1  count clock; stage 0 toggles on the falling edge, control and snapshot registers update on the rising edge.
- RST  input  1  reset, asynchronous, active-high.
- EN  input  1  count enable, sampled at posedge CLK.
- UP_DN  input  1  requested mode, 1 = up, 0 = down; accepted only while counting is disabled.
- CLR_OVF  input  1  clear request for OVF, sampled at posedge CLK.
- Q  output  WIDTH  live ripple count; may show transient values while the ripple settles.
- Q_CAP  output  WIDTH  snapshot of Q taken at posedge CLK.
- TC  output  1  registered terminal count: the next count event wraps.
- OVF  output  1  sticky wrap flag.
- MODE  output  1  currently active mode, 1 = up, 0 = down.

## Operation
- Internal registers updated at posedge CLK: en_r, mode_r, tc_r, clr_r, Q_CAP.
- en_r <= EN. clr_r <= CLR_OVF. Q_CAP <= Q.
- mode_r <= UP_DN only when en_r == 0 and EN == 0; otherwise mode_r holds.
- tc_r <= EN and (mode_r ? Q == all-ones : Q == 0).
- MODE = mode_r. TC = tc_r.
- Stage 0 (Q[0]) toggles on negedge CLK when en_r == 1.
- Stage i > 0: stage clock c_i = Q[i-1] XOR ~mode_r. Q[i] toggles on the falling edge of c_i when en_r == 1.
  - Up mode: Q[i] toggles when Q[i-1] falls 1->0.
  - Down mode: Q[i] toggles when Q[i-1] rises 0->1.
- Result: Q increments or decrements by 1 per enabled falling CLK edge, modulo 2^WIDTH, with natural wrap in both directions (all-ones->0 up, 0->all-ones down).
- Mode-change safety: mode_r changes only while en_r == 0. Any spurious c_i edge produced by a mode flip therefore cannot toggle a stage. Q is preserved across a mode change.
- OVF is updated at negedge CLK:
  - OVF <= 1 if en_r and tc_r (the count wrapping on this edge).
  - Else OVF <= 0 if clr_r.
  - Else OVF holds.
  - Set wins over a simultaneous clear.
- RST asserted: Q, Q_CAP, en_r, tc_r, clr_r and OVF go to 0 immediately, and mode_r goes to 1 (up). This takes effect at any time, including mid-ripple. Count resumes only after RST falls and en_r is subsequently re-sampled high.

## Timing
- EN high at posedge k: first count change on the negedge of cycle k, i.e. a half period later. Q_CAP reflects that change at posedge k+1.
- EN latency to count = 0.5 cycle. Count to Q_CAP latency = 0.5 cycle.
- Ripple settling requirement: WIDTH × (stage clk-to-q + XOR delay) < CLK low time. Q_CAP and tc_r are only guaranteed correct when this holds.
- TC is high during the cycle whose falling edge wraps the count. OVF rises on that same falling edge.
- CLR_OVF high at posedge k: OVF falls at the negedge of cycle k, unless a wrap occurs on that edge.
- UP_DN change with EN low for two consecutive posedges: MODE updates at the second posedge. A change while EN or en_r is high is ignored until both are low.

## Test plan
- Reset: RST pulse mid-count at Q=9 (WIDTH=4) -> Q=0, Q_CAP=0, TC=0, OVF=0, MODE=1 immediately, with no CLK edge needed.
- Up count: WIDTH=4, EN=1 for 17 cycles from 0 -> Q_CAP sequence 1..15,0,1; TC high exactly in the cycle Q_CAP=15; OVF rises on the 0 wrap and stays 1.
- Down count: EN=0, UP_DN=0 for 2 cycles, then EN=1 from Q=3 for 5 cycles -> Q_CAP 2,1,0,15,14; OVF set at the 0->15 transition; Q unchanged across the mode switch.
- Mode change while counting: UP_DN toggled while EN=1 -> MODE and count direction unchanged; after EN drops for 2 cycles, MODE follows UP_DN.
- OVF clear race: CLR_OVF asserted in the same cycle as TC=1 -> OVF stays 1. CLR_OVF asserted one cycle later with no wrap -> OVF=0 at the next negedge.
- Enable gating and WIDTH=8: EN toggling 1,0,1,1,0 from Q=0 -> Q_CAP 1,1,2,3,3. 300 enabled up-counts from 0 -> Q_CAP=44, OVF=1.
